// File: rtl/decode_stage_if.sv
// Fetch/writeback-to-decode bus and the ID/EX latch outputs of decode_stage.
// Suffixes are from the decode stage's point of view: the slave is the decoder.
interface decode_stage_if;
    logic [15:0] instr_i;
    logic [15:0] nextPc_i;
    logic        inValid_i;
    logic        stall_i;
    logic        flush_i;
    logic        wbEn_i;
    logic [2:0]  wbReg_i;
    logic [15:0] wbData_i;

    logic        outValid_o;
    logic [4:0]  outOpcode_o;
    logic [15:0] outPc_o;
    logic [15:0] outRsData_o;
    logic [15:0] outRtData_o;
    logic [15:0] outImm_o;
    logic [2:0]  outWrReg_o;
    logic        outWrEn_o;
    logic        haltOut_o;

    modport master (
        output instr_i, nextPc_i, inValid_i, stall_i, flush_i, wbEn_i, wbReg_i, wbData_i,
        input  outValid_o, outOpcode_o, outPc_o, outRsData_o, outRtData_o, outImm_o,
               outWrReg_o, outWrEn_o, haltOut_o
    );

    modport slave (
        input  instr_i, nextPc_i, inValid_i, stall_i, flush_i, wbEn_i, wbReg_i, wbData_i,
        output outValid_o, outOpcode_o, outPc_o, outRsData_o, outRtData_o, outImm_o,
               outWrReg_o, outWrEn_o, haltOut_o
    );
endinterface

// File: rtl/decode_stage.sv
// Decode stage: 8x16 register file, instruction decode, ID/EX latch and sticky halt.
// Define RF_BYPASS_EN to forward a same-cycle writeback value to the register reads.
module decode_stage (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave dec
);
    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_NOP  = 5'b00001;

    typedef struct packed {
        logic        valid;
        logic        wrEn;
        logic [4:0]  opcode;
        logic [15:0] pc;
        logic [15:0] rsData;
        logic [15:0] rtData;
        logic [15:0] imm;
        logic [2:0]  wrReg;
    } idex_t;

    logic [15:0] rf_q [8];
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [4:0]  opcode;
    logic [15:0] rsData;
    logic [15:0] rtData;
    logic [15:0] imm;
    logic [2:0]  rd;
    logic        decWrEn;
    logic        latchValid;
    idex_t       latch_q;
    idex_t       latch_d;
    logic        halt_q;
    logic        halt_d;

    assign rs     = dec.instr_i[10:8];
    assign rt     = dec.instr_i[7:5];
    assign opcode = dec.instr_i[15:11];

    // Writeback is independent of stall, flush and halt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= '0;
            end
        end else if (dec.wbEn_i) begin
            rf_q[dec.wbReg_i] <= dec.wbData_i;
        end
    end

    always_comb begin
        rsData = rf_q[rs];
        rtData = rf_q[rt];
`ifdef RF_BYPASS_EN
        if (dec.wbEn_i && (dec.wbReg_i == rs)) rsData = dec.wbData_i;
        if (dec.wbEn_i && (dec.wbReg_i == rt)) rtData = dec.wbData_i;
`endif
    end

    always_comb begin
        imm = '0;
        rd  = '0;
        unique case (dec.instr_i[15:14])
            2'b00: imm = {{5{dec.instr_i[10]}}, dec.instr_i[10:0]};
            2'b01: begin
                imm = {{11{dec.instr_i[4]}}, dec.instr_i[4:0]};
                rd  = dec.instr_i[7:5];
            end
            2'b10: rd = dec.instr_i[4:2];
            default: begin
                imm = {{8{dec.instr_i[7]}}, dec.instr_i[7:0]};
                rd  = dec.instr_i[10:8];
            end
        endcase
        decWrEn = (dec.instr_i[15:14] != 2'b00) && (opcode != OP_HALT) && (opcode != OP_NOP);
    end

    // Stall holds everything; flush only kills valid/wrEn and leaves the fields stale.
    always_comb begin
        latch_d    = latch_q;
        halt_d     = halt_q;
        latchValid = dec.inValid_i & ~halt_q;
        if (!dec.stall_i) begin
            if (dec.flush_i) begin
                latch_d.valid = 1'b0;
                latch_d.wrEn  = 1'b0;
            end else begin
                latch_d.valid  = latchValid;
                latch_d.wrEn   = latchValid & decWrEn;
                latch_d.opcode = opcode;
                latch_d.pc     = dec.nextPc_i;
                latch_d.rsData = rsData;
                latch_d.rtData = rtData;
                latch_d.imm    = imm;
                latch_d.wrReg  = rd;
                halt_d         = halt_q | (latchValid & (opcode == OP_HALT));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latch_q <= '0;
            halt_q  <= 1'b0;
        end else begin
            latch_q <= latch_d;
            halt_q  <= halt_d;
        end
    end

    assign dec.outValid_o  = latch_q.valid;
    assign dec.outWrEn_o   = latch_q.wrEn;
    assign dec.outOpcode_o = latch_q.opcode;
    assign dec.outPc_o     = latch_q.pc;
    assign dec.outRsData_o = latch_q.rsData;
    assign dec.outRtData_o = latch_q.rtData;
    assign dec.outImm_o    = latch_q.imm;
    assign dec.outWrReg_o  = latch_q.wrReg;
    assign dec.haltOut_o   = halt_q;
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed scenarios plus randomized traffic against a reference model.
// Compile with the same RF_BYPASS_EN setting as the design.
module tb_decode_stage;
    logic clk;
    logic rst;

    decode_stage_if dif ();

    decode_stage dut (
        .clk (clk),
        .rst (rst),
        .dec (dif)
    );

`ifdef RF_BYPASS_EN
    localparam bit BYPASS_ON = 1'b1;
`else
    localparam bit BYPASS_ON = 1'b0;
`endif

    typedef struct {
        logic        valid;
        logic        wrEn;
        logic        halt;
        logic [4:0]  opcode;
        logic [15:0] pc;
        logic [15:0] rsData;
        logic [15:0] rtData;
        logic [15:0] imm;
        logic [2:0]  wrReg;
    } exp_t;

    exp_t        expQ[$];
    exp_t        mdl;
    logic [15:0] mrf [8];
    logic        halted;
    int          checkCount = 0;
    int          passCount  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [15:0] sext(input int value, input int bits);
        int v;
        v = value;
        if (v >= (1 << (bits - 1))) v = v - (1 << bits);
        return 16'(v);
    endfunction

    function automatic logic [15:0] readReg(input logic [2:0] idx, input logic we,
                                            input logic [2:0] wr, input logic [15:0] wd);
        return (BYPASS_ON && we && (wr == idx)) ? wd : mrf[idx];
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < 8; i++) mrf[i] = '0;
        halted = 1'b0;
        mdl = '{valid: 1'b0, wrEn: 1'b0, halt: 1'b0, opcode: '0, pc: '0,
                rsData: '0, rtData: '0, imm: '0, wrReg: '0};
    endfunction

    // Called at a negedge; drives one cycle, predicts the post-edge outputs, returns at the next negedge.
    task automatic applyStimulus(input logic [15:0] instr, input logic [15:0] pc, input logic v,
                                 input logic st, input logic fl, input logic we,
                                 input logic [2:0] wr, input logic [15:0] wd);
        int   fmt;
        logic [4:0] op;
        dif.instr_i   = instr;
        dif.nextPc_i  = pc;
        dif.inValid_i = v;
        dif.stall_i   = st;
        dif.flush_i   = fl;
        dif.wbEn_i    = we;
        dif.wbReg_i   = wr;
        dif.wbData_i  = wd;
        fmt = int'(instr[15:14]);
        op  = instr[15:11];
        if (!st && fl) begin
            mdl.valid = 1'b0;
            mdl.wrEn  = 1'b0;
        end else if (!st) begin
            mdl.valid  = v && !halted;
            mdl.opcode = op;
            mdl.pc     = pc;
            mdl.rsData = readReg(instr[10:8], we, wr, wd);
            mdl.rtData = readReg(instr[7:5], we, wr, wd);
            case (fmt)
                0:       begin mdl.imm = sext(int'(instr[10:0]), 11); mdl.wrReg = '0; end
                1:       begin mdl.imm = sext(int'(instr[4:0]), 5);   mdl.wrReg = instr[7:5]; end
                2:       begin mdl.imm = '0;                          mdl.wrReg = instr[4:2]; end
                default: begin mdl.imm = sext(int'(instr[7:0]), 8);   mdl.wrReg = instr[10:8]; end
            endcase
            mdl.wrEn = mdl.valid && (fmt != 0) && (op != 5'd0) && (op != 5'd1);
            if (mdl.valid && (op == 5'd0)) halted = 1'b1;
        end
        mdl.halt = halted;
        if (we) mrf[wr] = wd;
        expQ.push_back(mdl);
        @(negedge clk);
    endtask

    task automatic doReset();
        rst           = 1'b1;
        dif.instr_i   = 16'($urandom);
        dif.nextPc_i  = 16'($urandom);
        dif.inValid_i = 1'b1;
        dif.stall_i   = 1'($urandom);
        dif.flush_i   = 1'($urandom);
        dif.wbEn_i    = 1'b1;
        dif.wbReg_i   = 3'($urandom);
        dif.wbData_i  = 16'($urandom);
        #1;
        checkOutput("resetAsync", 16'({dif.outValid_o, dif.outWrEn_o, dif.haltOut_o, dif.outOpcode_o,
                    dif.outWrReg_o} | dif.outPc_o | dif.outRsData_o | dif.outRtData_o | dif.outImm_o), 16'h0);
        modelReset();
        expQ.push_back(mdl);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: one scoreboard entry per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("outValid", 16'(dif.outValid_o), 16'(e.valid));
                checkOutput("outWrEn", 16'(dif.outWrEn_o), 16'(e.wrEn));
                checkOutput("haltOut", 16'(dif.haltOut_o), 16'(e.halt));
                if (e.valid) begin
                    checkOutput("outOpcode", 16'(dif.outOpcode_o), 16'(e.opcode));
                    checkOutput("outPc", dif.outPc_o, e.pc);
                    checkOutput("outRsData", dif.outRsData_o, e.rsData);
                    checkOutput("outRtData", dif.outRtData_o, e.rtData);
                    checkOutput("outImm", dif.outImm_o, e.imm);
                end
                if (e.wrEn) checkOutput("outWrReg", 16'(dif.outWrReg_o), 16'(e.wrReg));
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] rnd;
        logic [15:0] rTypeR3;
        int          waitCycles;
        rst = 1'b1;
        modelReset();
        @(negedge clk);
        doReset();

        for (int i = 0; i < 8; i++) begin
            applyStimulus({2'b10, 3'b000, 3'(i), 3'(7 - i), 3'b001, 2'b00}, 16'(2 * i + 2),
                          1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        end

        rTypeR3 = {2'b10, 3'b000, 3'd3, 3'd0, 3'd1, 2'b00};
        applyStimulus(rTypeR3, 16'h0100, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 16'hABCD);
        checkOutput("sameCycleRead", dif.outRsData_o, BYPASS_ON ? 16'hABCD : 16'h0000);
        applyStimulus(rTypeR3, 16'h0102, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        checkOutput("nextCycleRead", dif.outRsData_o, 16'hABCD);

        applyStimulus({2'b01, 3'b010, 3'd1, 3'd2, 5'b10000}, 16'h0104, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        checkOutput("immItype", dif.outImm_o, 16'hFFF0);
        applyStimulus({2'b11, 3'b000, 3'd5, 8'h7F}, 16'h0106, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        checkOutput("immLoad", dif.outImm_o, 16'h007F);
        checkOutput("wrRegLoad", 16'(dif.outWrReg_o), 16'd5);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'($urandom), 16'($urandom), 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0);
            checkOutput("stallHoldImm", dif.outImm_o, 16'h007F);
        end
        applyStimulus(16'h8123, 16'h0200, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0);
        checkOutput("flushValid", 16'(dif.outValid_o), 16'd0);
        checkOutput("flushWrEn", 16'(dif.outWrEn_o), 16'd0);

        applyStimulus(16'h0005, 16'h0202, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0);
        checkOutput("haltUnderFlush", 16'(dif.haltOut_o), 16'd0);

        applyStimulus(16'h0005, 16'h0204, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        checkOutput("haltSet", 16'(dif.haltOut_o), 16'd1);
        applyStimulus({2'b10, 3'b000, 3'd1, 3'd2, 3'd3, 2'b00}, 16'h0206, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        checkOutput("addAfterHalt", 16'(dif.outValid_o), 16'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(16'($urandom), 16'($urandom), 1'b1, 1'($urandom), 1'b0,
                          1'($urandom), 3'($urandom), 16'($urandom));
        end
        checkOutput("haltSticky", 16'(dif.haltOut_o), 16'd1);

        doReset();
        applyStimulus({2'b10, 3'b001, 3'd2, 3'd4, 3'd6, 2'b00}, 16'h0300, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        checkOutput("validAfterReset", 16'(dif.outValid_o), 16'd1);
        checkOutput("haltClearedByReset", 16'(dif.haltOut_o), 16'd0);

        applyStimulus({2'b11, 3'b001, 3'd4, 8'h80}, 16'h0302, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        applyStimulus(16'h4321, 16'h0304, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
        doReset();
        applyStimulus({2'b01, 3'b011, 3'd0, 3'd7, 5'b01111}, 16'h0306, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);

        for (int i = 0; i < 300; i++) begin
            rnd = 16'($urandom);
            if (rnd[15:11] == 5'd0) rnd[11] = 1'b1;
            applyStimulus(rnd, 16'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 5) == 0), 1'($urandom), 3'($urandom), 16'($urandom));
        end

        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 10) begin
            @(posedge clk);
            waitCycles++;
        end
        #2;
        if (expQ.size() > 0) checkOutput("scoreboardDrain", 16'(expQ.size()), 16'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Block SHALL have no parameters; all widths fixed at 16-bit data, 3-bit register index, 8 registers.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous reset, active-high.
REQ-004 instr  input  16  instruction word from fetch.
REQ-005 nextPc  input  16  PC+2 of that instruction, from fetch.
REQ-006 inValid  input  1  instr/nextPc valid this cycle.
REQ-007 stall  input  1  downstream stall; hold all outputs.
REQ-008 flush  input  1  discard the instruction being latched this cycle.
REQ-009 wbEn, wbReg[2:0], wbData[15:0]  input  1/3/16  register file write port from writeback.
REQ-010 outValid, outOpcode[4:0], outPc[15:0]  output  1/5/16  latched valid, opcode instr[15:11], nextPc.
REQ-011 outRsData, outRtData, outImm  output  16 each  operand A, operand B, extended immediate.
REQ-012 outWrReg[2:0], outWrEn  output  3/1  destination register and write enable.
REQ-013 haltOut  output  1  sticky halt indication, drives fetch halt.

Function
REQ-014 Register file SHALL be 8 x 16 flops, written on rising clk when wbEn=1; reads combinational from rs=instr[10:8], rt=instr[7:5].
REQ-015 All outputs except haltOut SHALL be registered (ID/EX latch); latency instr -> outputs exactly 1 cycle.
REQ-016 Formats by instr[15:14]: 00 = control (imm = sext instr[10:0]), 01 = I-type (imm = sext instr[4:0], rd = instr[7:5]), 10 = R-type (imm = 0, rd = instr[4:2]), 11 = load-imm (imm = sext instr[7:0], rd = instr[10:8]).
REQ-017 Opcode 5'b00000 = HALT, 5'b00001 = NOP; both SHALL latch outWrEn=0; control format SHALL latch outWrEn=0; all others outWrEn=1.
REQ-018 Priority each edge: rst > stall > flush > normal latch.
REQ-019 stall=1: every output register SHALL hold its value, including outValid; flush ignored that cycle.
REQ-020 flush=1 and stall=0: outValid SHALL latch 0, outWrEn SHALL latch 0; other fields don't-care.
REQ-021 Normal: outValid SHALL latch inValid & ~haltOut; outWrEn SHALL latch 0 whenever latched outValid=0.
REQ-022 haltOut SHALL set on the edge a valid HALT is latched (stall=0, flush=0) and remain 1 until rst; instructions arriving afterwards latch outValid=0.
REQ-023 Register file writes SHALL occur regardless of stall, flush, or haltOut.
REQ-024 Write to wbReg while same register is read in same cycle: behaviour per REQ-028.

Reset
REQ-025 On rst=1 all output registers SHALL clear to 0 immediately (asynchronous), including haltOut.
REQ-026 All 8 registers SHALL clear to 16'h0000 on rst.
REQ-027 rst asserted mid-stall or mid-halt SHALL clear state; first edge after release latches normally.

Configuration
REQ-028 Macro RF_BYPASS_EN: defined -> read of register equal to wbReg with wbEn=1 SHALL return wbData in same cycle; undefined -> SHALL return pre-write value (new value visible next cycle).

Verification
REQ-029 Reset: rst=1 with arbitrary inputs -> all outputs 0; after release, read of r0..r7 returns 0000.
REQ-030 Write/read: wbEn=1 wbReg=3 wbData=ABCD, next cycle R-type with rs=3 -> outRsData=ABCD one cycle later; same-cycle read returns ABCD with RF_BYPASS_EN, 0000 without.
REQ-031 Immediates: I-type instr[4:0]=5'b10000 -> outImm=FFF0; load-imm instr[7:0]=8'h7F -> outImm=007F, outWrReg=instr[10:8].
REQ-032 Stall/flush: stall=1 for 3 cycles with flush=1 -> outputs unchanged; stall=0 flush=1 -> outValid=0, outWrEn=0.
REQ-033 Halt: valid HALT latched -> haltOut=1 next edge, following valid ADD latches outValid=0; stays until rst pulse clears haltOut.
REQ-034 Halt under flush: HALT with flush=1 -> haltOut stays 0.
